// File: rtl/mcu_spi_slave_pkg.sv
// Shared types and constants for the MCU SPI register-access slave.
package mcu_spi_slave_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_CS,
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } spi_state_e;

    localparam logic SPI_MISO_IDLE = 1'b1;

endpackage

// File: rtl/mcu_spi_slave_pin_sync.sv
// Multi-flop synchronizer for one SPI pin, with level and single-cycle rise/fall outputs.
module mcu_spi_slave_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk28,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/mcu_spi_slave.sv
// SPI mode-0 slave turning MCU frames (address byte + data bytes) into register-write strobes.
// Optional readback on MISO is enabled by defining MCU_SPI_READBACK_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_WAIT_CS | after reset; waits for CS_N seen high so a cut frame is dropped
// ST_IDLE    | CS_N high, waiting for its falling edge
// ST_ADDR    | shifting in the address byte
// ST_DATA    | shifting in data bytes; each full byte pulses cmd_valid
module mcu_spi_slave
    import mcu_spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk28,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    output logic       cmd_valid,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       frame_err
);

    logic sck_lvl, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic cs_lvl, cs_rise, cs_fall;

    // CS resets to "low" so a frame cut by reset is not mistaken for CS_N high.
    mcu_spi_slave_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk28(clk28), .rst(rst), .pin_i(spi_sck),
        .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall));
    mcu_spi_slave_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk28(clk28), .rst(rst), .pin_i(spi_mosi),
        .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));
    mcu_spi_slave_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk28(clk28), .rst(rst), .pin_i(spi_cs_n),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));

    spi_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       got_q, got_d;
    logic [7:0] cmd_addr_q, cmd_addr_d;
    logic [7:0] cmd_data_q, cmd_data_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] rd_addr_q, rd_addr_d;
    logic       rd_upd;

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_WAIT_CS;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            ptr_q       <= 8'h00;
            got_q       <= 1'b0;
            cmd_addr_q  <= 8'h00;
            cmd_data_q  <= 8'h00;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            rd_addr_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            got_q       <= got_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        got_d       = got_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_upd      = 1'b0;
        case (state_q)
            ST_WAIT_CS: if (cs_lvl) state_d = ST_IDLE;
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_ADDR;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_ADDR: begin
                if (sck_rise) begin
                    shift_d   = {shift_q[6:0], mosi_lvl};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        ptr_d     = shift_d;
                        rd_addr_d = shift_d;
                        rd_upd    = 1'b1;
                        got_d     = 1'b0;
                        state_d   = ST_DATA;
                    end
                end
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (sck_rise) begin
                    shift_d   = {shift_q[6:0], mosi_lvl};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        cmd_valid_d = 1'b1;
                        cmd_addr_d  = ptr_q;
                        cmd_data_d  = shift_d;
                        ptr_d       = ptr_q + 8'd1;
                        rd_addr_d   = ptr_q + 8'd1;
                        rd_upd      = 1'b1;
                        got_d       = 1'b1;
                    end
                end
                // A byte completing in the same cycle as CS_N rising still counts.
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (bit_cnt_d != 3'd0) || !got_d;
                end
            end
            default: state_d = ST_WAIT_CS;
        endcase
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_data  = cmd_data_q;
    assign frame_err = frame_err_q;

`ifdef MCU_SPI_READBACK_EN
    logic [1:0] upd_q;
    logic [7:0] miso_sh_q;
    logic       miso_q;

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            upd_q     <= 2'b00;
            miso_sh_q <= 8'hFF;
            miso_q    <= SPI_MISO_IDLE;
        end else begin
            upd_q <= {upd_q[0], rd_upd};
            if (upd_q[1]) begin
                miso_sh_q <= rd_data;
            end else if (sck_fall && state_q == ST_DATA) begin
                miso_sh_q <= {miso_sh_q[6:0], 1'b1};
            end
            if (state_q != ST_DATA) begin
                miso_q <= SPI_MISO_IDLE;
            end else if (sck_fall) begin
                miso_q <= miso_sh_q[7];
            end
        end
    end

    assign spi_miso = miso_q;
    assign rd_addr  = rd_addr_q;
    logic unused_sync;
    assign unused_sync = ^{sck_lvl, mosi_rise, mosi_fall};
`else
    assign spi_miso = SPI_MISO_IDLE;
    assign rd_addr  = 8'h00;
    logic unused_sync;
    assign unused_sync = ^{sck_lvl, sck_fall, mosi_rise, mosi_fall, rd_data, rd_addr_q, rd_upd};
`endif

endmodule
